// File: rtl/digit_serial_adder2_pkg.sv
// Shared definitions for the digit-serial adder: controller states, digit width
// and the digit-counter width helper.
package digit_serial_adder2_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index N = width/2 digits; a single digit still needs one bit.
    function automatic int cnt_width(input int width);
        int n;
        n = width / DIGIT_W;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder2_slice.sv
// Purely combinational 2-bit ripple-carry adder slice, kept as its own module so
// it maps to a separate cell/macro.
module adder2_slice (
    input  logic ci,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic s0,
    output logic s1,
    output logic co
);

    logic w_c0;

    assign s0   = a0 ^ b0 ^ ci;
    assign w_c0 = (a0 & b0) | (ci & (a0 ^ b0));
    assign s1   = a1 ^ b1 ^ w_c0;
    assign co   = (a1 & b1) | (w_c0 & (a1 ^ b1));

endmodule

// File: rtl/digit_serial_adder2.sv
// Digit-serial wide adder: accepts operands over valid/ready, adds one 2-bit digit
// per clock through adder2_slice (LSB first), then offers {cout,sum} over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | in_ready high, waiting for an operand bundle
// RUN     | one digit per cycle through the slice
// DONE    | result held on sum/cout until out_ready
module digit_serial_adder2
    import digit_serial_adder2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_s0;
    logic             w_s1;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_nxt;

    adder2_slice u_slice (
        .ci (r_carry),
        .a0 (r_a_sh[0]),
        .a1 (r_a_sh[1]),
        .b0 (r_b_sh[0]),
        .b1 (r_b_sh[1]),
        .s0 (w_s0),
        .s1 (w_s1),
        .co (w_co)
    );

    // New digit enters at the top; after N shifts digit 0 sits at bits [1:0].
    generate
        if (WIDTH == DIGIT_W) begin : g_sum_single
            assign w_sum_nxt = {w_s1, w_s0};
        end else begin : g_sum_shift
            assign w_sum_nxt = {w_s1, w_s0, r_sum_sh[WIDTH-1:DIGIT_W]};
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)      w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == LAST) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)     w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum_sh <= w_sum_nxt;
                    r_a_sh   <= r_a_sh >> DIGIT_W;
                    r_b_sh   <= r_b_sh >> DIGIT_W;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum_sh;
    assign cout      = r_carry;

endmodule

// File: tb/tb_digit_serial_adder2.sv
// Scoreboard bench for digit_serial_adder2: WIDTH=8 instance for directed and random
// traffic, WIDTH=2 instance swept exhaustively; expected sums come from a + b + cin.
module tb_digit_serial_adder2;

    localparam int W = 8;
    localparam int N = W / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
    logic [1:0]   a2, b2, sum2;

    int tests = 0;
    int fails = 0;

    logic [W:0] q8[$];
    logic [2:0] q2[$];
    logic [W:0] e8;
    logic [2:0] e2;

    digit_serial_adder2 #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    digit_serial_adder2 #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop and compare on each completed output handshake.
    logic         hold_prev = 1'b0;
    logic [W-1:0] sum_prev = '0;
    logic         cout_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (hold_prev) begin
                chk("hold_sum", 32'(sum), 32'(sum_prev));
                chk("hold_cout", 32'(cout), 32'(cout_prev));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_ready) begin
                if (q8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out8: got 0x%0h with empty scoreboard", {cout, sum});
                end else begin
                    e8 = q8.pop_front();
                    chk("result8", 32'({cout, sum}), 32'(e8));
                end
            end
        end
        hold_prev = rst_n && out_valid && !out_ready;
        sum_prev  = sum;
        cout_prev = cout;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out2: got 0x%0h with empty scoreboard", {cout2, sum2});
            end else begin
                e2 = q2.pop_front();
                chk("result2", 32'({cout2, sum2}), 32'(e2));
            end
        end
    end

    task automatic wait_ready8();
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("timeout_in_ready8", 32'(in_ready), 32'd1);
    endtask

    // One operation; hold = cycles out_ready stays low in DONE, keep = in_valid stays
    // high with changing operands while the operation runs.
    task automatic send8(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input int hold, input bit keep);
        logic [W:0] e;
        int lat;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        out_ready = (hold == 0);
        wait_ready8();
        @(posedge clk);
        e = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        q8.push_back(e);
        #1;
        if (!keep) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (keep) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency8", 32'(lat), 32'(N));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", 32'({in_ready, out_valid}), 32'b10);
    endtask

    // in_valid held high across back-to-back operations with out_ready tied high.
    task automatic stream8(input int k);
        logic [W:0] e;
        int low;
        out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        in_valid = 1'b1;
        wait_ready8();
        for (int i = 0; i < k; i++) begin
            e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            @(posedge clk);
            q8.push_back(e);
            #1;
            if (i == k - 1) in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            low = 0;
            while (!in_ready && low < 50) begin
                @(posedge clk); #1;
                low++;
            end
            chk("in_ready_gap", 32'(low), 32'(N + 1));
        end
    endtask

    initial begin
        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        in_valid2 = 0; a2 = '0; b2 = '0; cin2 = 0; out_ready2 = 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum_cout", 32'({cout, sum}), 32'd0);
        chk("rst_in_ready2", 32'(in_ready2), 32'd1);

        send8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        send8(8'h55, 8'hAA, 1'b1, 0, 1'b0);
        send8(8'h55, 8'hAA, 1'b0, 0, 1'b0);
        send8(8'h3C, 8'h0F, 1'b0, 5, 1'b0);
        send8(8'h12, 8'hF7, 1'b1, 0, 1'b1);
        for (int i = 0; i < 20; i++)
            send8(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom));

        // Reset during the second RUN cycle: operation is dropped, nothing emitted.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        wait_ready8();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_in_run", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst_state", 32'({in_ready, busy, out_valid}), 32'b100);
        chk("midrun_rst_sum", 32'({cout, sum}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_out_after_rst", 32'(out_valid), 32'd0);
        end

        stream8(6);

        for (int i = 0; i < 32; i++) begin
            int t;
            int lat;
            logic [4:0] v;
            v = 5'(i);
            a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4];
            in_valid2 = 1'b1;
            t = 0;
            while (!in_ready2 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk);
            q2.push_back({1'b0, a2} + {1'b0, b2} + {2'b00, cin2});
            #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("latency2", 32'(lat), 32'd1);
        end

        repeat (6) @(posedge clk);
        #1;
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
